// File: rtl/divider.sv
// Sequential restoring shift-subtract divider: unsigned quotient and remainder,
// one quotient bit per clock, with the trial subtraction done on an N+1 bit Adder.

module Adder #(
  parameter int W = 9
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_carry,
  output logic [W-1:0] o_sum
);

  assign o_sum = i_a + i_b + {{(W-1){1'b0}}, i_carry};

endmodule

module divider #(
  parameter int N = 8
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic         o_busy,
  output logic         o_finished,
  output logic [N-1:0] o_quotient,
  output logic [N-1:0] o_remainder,
  output logic         o_div_zero
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

  state_t         state_q;
  logic [CW-1:0]  count_q;
  logic [N-1:0]   workRem_q;
  logic [N-1:0]   workQuo_q;
  logic [N-1:0]   divisor_q;
  logic           zero_q;
  logic           busy_q;
  logic           finished_q;
  logic [N-1:0]   quotient_q;
  logic [N-1:0]   remainder_q;
  logic           divZero_q;

  logic [N:0]     remShift;
  logic [N:0]     diff;
  logic           doSub;
  logic [N-1:0]   rem_d;
  logic [N-1:0]   quo_d;

  assign remShift = {workRem_q, workQuo_q[N-1]};

  Adder #(.W(N + 1)) trialSub (
    .i_a     (remShift),
    .i_b     (~{1'b0, divisor_q}),
    .i_carry (1'b1),
    .o_sum   (diff)
  );

  // The shifted remainder can reach 2D-1 and so needs the extra top bit:
  // when that bit is set the subtraction always succeeds regardless of borrow.
  assign doSub = remShift[N] | ~diff[N];
  assign rem_d = doSub ? diff[N-1:0] : remShift[N-1:0];
  assign quo_d = {workQuo_q[N-2:0], doSub};

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      workRem_q   <= '0;
      workQuo_q   <= '0;
      divisor_q   <= '0;
      zero_q      <= 1'b0;
      busy_q      <= 1'b0;
      finished_q  <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      divZero_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          finished_q <= 1'b0;
          if (i_start) begin
            workQuo_q <= i_dividend;
            divisor_q <= i_divisor;
            workRem_q <= '0;
            count_q   <= '0;
            zero_q    <= (i_divisor == '0);
            busy_q    <= 1'b1;
            state_q   <= DIVIDE;
          end
        end
        DIVIDE: begin
          workRem_q <= rem_d;
          workQuo_q <= quo_d;
          count_q   <= count_q + 1'b1;
          if (count_q == LAST) begin
            state_q     <= DONE;
            finished_q  <= 1'b1;
            quotient_q  <= quo_d;
            remainder_q <= rem_d;
            divZero_q   <= zero_q;
          end
        end
        DONE: begin
          finished_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_busy      = busy_q;
  assign o_finished  = finished_q;
  assign o_quotient  = quotient_q;
  assign o_remainder = remainder_q;
  assign o_div_zero  = divZero_q;

endmodule
